// File: rtl/rv_execute_phase.sv
// Execute stage of the RV32IM_Zbb pipeline: operand forwarding/immediate muxes, one ALU/Zbb op per cycle, registered result.
// Optional multiply ops (MUL/MULH/MULHSU/MULHU) are built only when RV_EXEC_MUL_EN is defined.
module rv_execute_phase #(
    parameter int XLEN = 32
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rs1_i,
    input  logic [XLEN-1:0] rs2_i,
    input  logic [XLEN-1:0] imm_i,
    input  logic [4:0]      alu_op_i,
    input  logic [XLEN-1:0] ex_mem_i,
    input  logic [XLEN-1:0] mem_wb_i,
    input  logic [1:0]      mux1_i,
    input  logic [1:0]      mux2_i,
    input  logic            mux3_i,
    output logic [XLEN-1:0] res_o
);

    function automatic logic [5:0] f_clz(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 0; i < 32; i++) begin
            if (v[i]) n = 6'(31 - i);
        end
        return n;
    endfunction

    function automatic logic [5:0] f_ctz(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd32;
        for (int i = 31; i >= 0; i--) begin
            if (v[i]) n = 6'(i);
        end
        return n;
    endfunction

    function automatic logic [5:0] f_cpop(input logic [31:0] v);
        logic [5:0] n;
        n = 6'd0;
        for (int i = 0; i < 32; i++) begin
            n = n + {5'd0, v[i]};
        end
        return n;
    endfunction

    function automatic logic [31:0] f_orc_b(input logic [31:0] v);
        logic [31:0] r;
        r = 32'd0;
        for (int i = 0; i < 4; i++) begin
            r[8*i +: 8] = (v[8*i +: 8] != 8'd0) ? 8'hFF : 8'h00;
        end
        return r;
    endfunction

    logic [XLEN-1:0] op_a_s;
    logic [XLEN-1:0] op2_tmp_s;
    logic [XLEN-1:0] op_b_s;
    logic [4:0]      sh_s;
    logic [XLEN-1:0] alu_res_s;
    logic [XLEN-1:0] res_r;
`ifdef RV_EXEC_MUL_EN
    logic [63:0]     prod_ss_s;
    logic [63:0]     prod_su_s;
    logic [63:0]     prod_uu_s;
`endif

    // Operand selection: forwarding for A and operand2_tmp, then immediate select for B
    always_comb begin
        op_a_s    = rs1_i;
        op2_tmp_s = rs2_i;
        case (mux1_i)
            2'b01:   op_a_s = ex_mem_i;
            2'b10:   op_a_s = mem_wb_i;
            default: op_a_s = rs1_i;
        endcase
        case (mux2_i)
            2'b01:   op2_tmp_s = ex_mem_i;
            2'b10:   op2_tmp_s = mem_wb_i;
            default: op2_tmp_s = rs2_i;
        endcase
        if (mux3_i) begin
            op_b_s = imm_i;
        end else begin
            op_b_s = op2_tmp_s;
        end
        sh_s = op_b_s[4:0];
    end

`ifdef RV_EXEC_MUL_EN
    // Signedness is handled by explicit 64-bit extension so every product is a plain unsigned multiply
    always_comb begin
        prod_ss_s = {{32{op_a_s[31]}}, op_a_s} * {{32{op_b_s[31]}}, op_b_s};
        prod_su_s = {{32{op_a_s[31]}}, op_a_s} * {32'd0, op_b_s};
        prod_uu_s = {32'd0, op_a_s} * {32'd0, op_b_s};
    end
`endif

    // ALU / bit-manipulation result
    always_comb begin
        alu_res_s = 32'd0;
        case (alu_op_i)
            5'b00000: alu_res_s = op_a_s + op_b_s;
            5'b00001: alu_res_s = {26'd0, f_clz(op_a_s)};
            5'b00010: alu_res_s = {26'd0, f_ctz(op_a_s)};
            5'b00011: alu_res_s = {26'd0, f_cpop(op_a_s)};
            5'b00100: alu_res_s = op_a_s - op_b_s;
            5'b00101: alu_res_s = op_a_s & op_b_s;
            5'b00110: alu_res_s = op_a_s | op_b_s;
            5'b00111: alu_res_s = op_a_s ^ op_b_s;
            5'b01000: alu_res_s = op_a_s << sh_s;
            5'b01001: alu_res_s = op_a_s >> sh_s;
            5'b01010: alu_res_s = $unsigned($signed(op_a_s) >>> sh_s);
            5'b01011: alu_res_s = {31'd0, $signed(op_a_s) < $signed(op_b_s)};
            5'b01100: alu_res_s = {31'd0, op_a_s < op_b_s};
            5'b01101: alu_res_s = op_a_s & ~op_b_s;
            5'b01110: alu_res_s = op_a_s | ~op_b_s;
            5'b01111: alu_res_s = ~(op_a_s ^ op_b_s);
            5'b10000: alu_res_s = ($signed(op_a_s) < $signed(op_b_s)) ? op_a_s : op_b_s;
            5'b10001: alu_res_s = (op_a_s < op_b_s) ? op_a_s : op_b_s;
            5'b10010: alu_res_s = ($signed(op_a_s) < $signed(op_b_s)) ? op_b_s : op_a_s;
            5'b10011: alu_res_s = (op_a_s < op_b_s) ? op_b_s : op_a_s;
            5'b10100: alu_res_s = {{24{op_a_s[7]}}, op_a_s[7:0]};
            5'b10101: alu_res_s = {{16{op_a_s[15]}}, op_a_s[15:0]};
            5'b10110: alu_res_s = {16'd0, op_a_s[15:0]};
            // a shift by 32 yields 0, so a zero rotate amount needs no special case
            5'b10111: alu_res_s = (op_a_s << sh_s) | (op_a_s >> (6'd32 - {1'b0, sh_s}));
            5'b11000: alu_res_s = (op_a_s >> sh_s) | (op_a_s << (6'd32 - {1'b0, sh_s}));
            5'b11001: alu_res_s = f_orc_b(op_a_s);
            5'b11010: alu_res_s = {op_a_s[7:0], op_a_s[15:8], op_a_s[23:16], op_a_s[31:24]};
`ifdef RV_EXEC_MUL_EN
            5'b11011: alu_res_s = prod_uu_s[31:0];
            5'b11100: alu_res_s = prod_ss_s[63:32];
            5'b11101: alu_res_s = prod_su_s[63:32];
            5'b11110: alu_res_s = prod_uu_s[63:32];
`endif
            default:  alu_res_s = 32'd0;
        endcase
    end

    // EX/MEM result register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            res_r <= 32'd0;
        end else begin
            res_r <= alu_res_s;
        end
    end

    assign res_o = res_r;

endmodule

// File: tb/tb_rv_execute_phase.sv
// Self-checking bench for rv_execute_phase: directed cases plus random ops against a behavioural model.
module tb_rv_execute_phase;

    logic        clk;
    logic        rst_n;
    logic [31:0] rs1_i;
    logic [31:0] rs2_i;
    logic [31:0] imm_i;
    logic [4:0]  alu_op_i;
    logic [31:0] ex_mem_i;
    logic [31:0] mem_wb_i;
    logic [1:0]  mux1_i;
    logic [1:0]  mux2_i;
    logic        mux3_i;
    logic [31:0] res_o;

    int n_checks;
    int n_fail;

    rv_execute_phase #(.XLEN(32)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rs1_i    (rs1_i),
        .rs2_i    (rs2_i),
        .imm_i    (imm_i),
        .alu_op_i (alu_op_i),
        .ex_mem_i (ex_mem_i),
        .mem_wb_i (mem_wb_i),
        .mux1_i   (mux1_i),
        .mux2_i   (mux2_i),
        .mux3_i   (mux3_i),
        .res_o    (res_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural reference for one operation on already-selected operands
    function automatic logic [31:0] model(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b);
        int          sh;
        int          n;
        int          sa;
        byte         bb;
        shortint     hh;
        logic [63:0] dbl;
        logic [31:0] r;
        longint      p;
        logic [63:0] up;
        sh = int'(b[4:0]);
        r  = 32'd0;
        case (op)
            5'd0:  r = a + b;
            5'd1:  begin n = 0; while (n < 32 && a[31-n] == 1'b0) n++; r = 32'(n); end
            5'd2:  begin n = 0; while (n < 32 && a[n] == 1'b0) n++; r = 32'(n); end
            5'd3:  r = 32'($countones(a));
            5'd4:  r = a - b;
            5'd5:  r = a & b;
            5'd6:  r = a | b;
            5'd7:  r = a ^ b;
            5'd8:  r = a << sh;
            5'd9:  r = a >> sh;
            5'd10: begin sa = int'(a); r = 32'(sa >>> sh); end
            5'd11: r = (int'(a) < int'(b)) ? 32'd1 : 32'd0;
            5'd12: r = (a < b) ? 32'd1 : 32'd0;
            5'd13: r = a & ~b;
            5'd14: r = a | ~b;
            5'd15: r = ~(a ^ b);
            5'd16: r = (int'(a) < int'(b)) ? a : b;
            5'd17: r = (a < b) ? a : b;
            5'd18: r = (int'(a) > int'(b)) ? a : b;
            5'd19: r = (a > b) ? a : b;
            5'd20: begin bb = a[7:0]; r = 32'(int'(bb)); end
            5'd21: begin hh = a[15:0]; r = 32'(int'(hh)); end
            5'd22: r = a & 32'h0000FFFF;
            5'd23: begin dbl = {a, a} << sh; r = dbl[63:32]; end
            5'd24: begin dbl = {a, a} >> sh; r = dbl[31:0]; end
            5'd25: begin
                for (int i = 0; i < 4; i++) r[8*i +: 8] = (a[8*i +: 8] != 8'd0) ? 8'hFF : 8'h00;
            end
            5'd26: r = {<<8{a}};
`ifdef RV_EXEC_MUL_EN
            5'd27: begin up = {32'd0, a} * {32'd0, b}; r = up[31:0]; end
            5'd28: begin p = longint'(int'(a)) * longint'(int'(b)); r = p[63:32]; end
            5'd29: begin p = longint'(int'(a)) * longint'({32'd0, b}); r = p[63:32]; end
            5'd30: begin up = {32'd0, a} * {32'd0, b}; r = up[63:32]; end
`endif
            default: r = 32'd0;
        endcase
        return r;
    endfunction

    task automatic check(input string tag, input logic [31:0] exp);
        n_checks++;
        assert (res_o === exp) else begin
            n_fail++;
            $error("FAIL %s: res_o=%h expected %h", tag, res_o, exp);
        end
    endtask

    task automatic run(input string tag, input logic [4:0] op, input logic [31:0] r1, input logic [31:0] r2,
                       input logic [31:0] im, input logic [31:0] ex, input logic [31:0] wb,
                       input logic [1:0] m1, input logic [1:0] m2, input logic m3, input logic [31:0] exp);
        alu_op_i = op; rs1_i = r1; rs2_i = r2; imm_i = im; ex_mem_i = ex; mem_wb_i = wb;
        mux1_i = m1; mux2_i = m2; mux3_i = m3;
        @(posedge clk);
        #1;
        check(tag, exp);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] a, b, r1, r2, im, ex, wb, exp;
        logic [1:0]  m1, m2;
        logic        m3;
        logic [4:0]  op;
        n_checks = 0;
        n_fail   = 0;

        rst_n = 1'b0;
        rs1_i = $urandom; rs2_i = $urandom; imm_i = $urandom; ex_mem_i = $urandom; mem_wb_i = $urandom;
        alu_op_i = 5'd0; mux1_i = 2'd0; mux2_i = 2'd0; mux3_i = 1'b0;
        #1;
        check("reset_async", 32'd0);
        repeat (3) @(posedge clk);
        #1;
        check("reset_held", 32'd0);
        #2 rst_n = 1'b1;

        run("clz_a",   5'b00001, 32'hA, 32'hA, 32'hA, 32'hA, 32'hA, 2'd0, 2'd0, 1'b0, 32'd28);
        run("ctz_a",   5'b00010, 32'hA, 32'hA, 32'hA, 32'hA, 32'hA, 2'd0, 2'd0, 1'b0, 32'd1);
        run("cpop_a",  5'b00011, 32'hA, 32'hA, 32'hA, 32'hA, 32'hA, 2'd0, 2'd0, 1'b0, 32'd2);
        run("clz_0",   5'b00001, 32'h0, 32'h5, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 32'd32);
        run("ctz_0",   5'b00010, 32'h0, 32'h5, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 32'd32);
        run("cpop_ff", 5'b00011, 32'hFFFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0, 2'd0, 2'd0, 1'b0, 32'd32);
        run("fwd_exmem", 5'b00000, 32'd1, 32'd2, 32'd0, 32'd5, 32'd9, 2'b01, 2'b00, 1'b0, 32'd7);
        run("fwd_memwb", 5'b00000, 32'd1, 32'd2, 32'd0, 32'd5, 32'd9, 2'b10, 2'b01, 1'b0, 32'd14);
        run("fwd_sel11", 5'b00000, 32'd1, 32'd2, 32'd0, 32'd5, 32'd9, 2'b11, 2'b11, 1'b0, 32'd3);
        run("fwd_b_wb",  5'b00000, 32'd1, 32'd2, 32'd0, 32'd5, 32'd9, 2'b00, 2'b10, 1'b0, 32'd10);
        run("imm_add", 5'b00000, 32'd10, 32'd11, 32'hFFFFFFFD, 32'd0, 32'd0, 2'd0, 2'd0, 1'b1, 32'd7);
        run("sub_wrap", 5'b00100, 32'd10, 32'd11, 32'hFFFFFFFD, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'hFFFFFFFF);
        run("slt",  5'b01011, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd1);
        run("sltu", 5'b01100, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0);
        run("min",  5'b10000, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'hFFFFFFFF);
        run("minu", 5'b10001, 32'hFFFFFFFF, 32'd1, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd1);
        run("sra4", 5'b01010, 32'hFFFFFFFF, 32'd4, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'hFFFFFFFF);
        run("sll_hi_ignored", 5'b01000, 32'h1, 32'h24, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'h10);
        run("rev8",  5'b11010, 32'h12003400, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'h00340012);
        run("orcb",  5'b11001, 32'h12003400, 32'd0, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'hFF00FF00);
        run("rol8",  5'b10111, 32'h12003400, 32'd8, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'h00340012);
        run("op31",  5'b11111, 32'h12003400, 32'd8, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0);
`ifdef RV_EXEC_MUL_EN
        run("mulhu", 5'b11110, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd1);
        run("mulh",  5'b11100, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'hFFFFFFFF);
`else
        run("mulhu_off", 5'b11110, 32'hFFFFFFFF, 32'd2, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0);
        run("mul_off",   5'b11011, 32'h3, 32'd2, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd0);
`endif

        // Back-to-back random operations through the full mux path
        for (int k = 0; k < 400; k++) begin
            op = 5'($urandom_range(0, 31));
            r1 = $urandom; r2 = $urandom; im = $urandom; ex = $urandom; wb = $urandom;
            if ($urandom_range(0, 7) == 0) r1 = r1 >> $urandom_range(0, 31);
            m1 = 2'($urandom_range(0, 3));
            m2 = 2'($urandom_range(0, 3));
            m3 = 1'($urandom_range(0, 1));
            a = (m1 == 2'd1) ? ex : (m1 == 2'd2) ? wb : r1;
            b = m3 ? im : ((m2 == 2'd1) ? ex : (m2 == 2'd2) ? wb : r2);
            exp = model(op, a, b);
            run("random", op, r1, r2, im, ex, wb, m1, m2, m3, exp);
        end

        // Reset asserted off-edge while a nonzero result is held
        run("pre_reset", 5'b00000, 32'd3, 32'd4, 32'd0, 32'd0, 32'd0, 2'd0, 2'd0, 1'b0, 32'd7);
        #3 rst_n = 1'b0;
        #1;
        check("reset_mid", 32'd0);
        @(posedge clk);
        #1;
        check("reset_mid_held", 32'd0);
        #2 rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("first_capture", 32'd7);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/rv_execute_phase.md
Name: rv_execute_phase

Overview:
Execute stage of the RV32IM_Zbb pipeline. It selects the two operands through forwarding and immediate muxes, performs one ALU/bit-manipulation operation per cycle, and registers the result for the EX/MEM boundary. Pure datapath: no stall or handshake; the control unit drives the mux selects and alu_op_i every cycle.

Parameters:
XLEN, 32, datapath width; only 32 is supported.

Ports:
clk  in  1  clock; all state updates on the rising edge
rst_n  in  1  asynchronous active-low reset
rs1_i  in  32  register-file operand 1
rs2_i  in  32  register-file operand 2
imm_i  in  32  sign-extended immediate from decode
alu_op_i  in  5  operation select, encoding below
ex_mem_i  in  32  forwarded result from the EX/MEM register
mem_wb_i  in  32  forwarded result from the MEM/WB register
mux1_i  in  2  operand A select
mux2_i  in  2  forwarding select for operand2_tmp
mux3_i  in  1  operand B select
res_o  out  32  registered ALU result

Behaviour:
- Operand A, selected by mux1_i: 00 rs1_i, 01 ex_mem_i, 10 mem_wb_i, 11 rs1_i.
- operand2_tmp, selected by mux2_i: 00 rs2_i, 01 ex_mem_i, 10 mem_wb_i, 11 rs2_i.
- Operand B, selected by mux3_i: 0 operand2_tmp, 1 imm_i.
- Combinational ALU result by alu_op_i (A = operand A, B = operand B, sh = B[4:0]):
  - 00000 ADD A+B
  - 00001 CLZ(A)
  - 00010 CTZ(A)
  - 00011 CPOP(A)
  - 00100 SUB A-B
  - 00101 AND
  - 00110 OR
  - 00111 XOR
  - 01000 SLL A<<sh
  - 01001 SRL, logical
  - 01010 SRA, arithmetic
  - 01011 SLT, signed, result 1/0
  - 01100 SLTU, unsigned, result 1/0
  - 01101 ANDN A&~B
  - 01110 ORN A|~B
  - 01111 XNOR ~(A^B)
  - 10000 MIN, signed
  - 10001 MINU
  - 10010 MAX, signed
  - 10011 MAXU
  - 10100 SEXT.B, sign-extend A[7:0]
  - 10101 SEXT.H, sign-extend A[15:0]
  - 10110 ZEXT.H, zero-extend A[15:0]
  - 10111 ROL by sh
  - 11000 ROR by sh
  - 11001 ORC.B: each result byte is 0xFF if the corresponding A byte is nonzero, else 0x00
  - 11010 REV8, byte reverse
  - 11011-11110 multiply ops (see Optional Feature)
  - 11111 and all unused codes: result 0
- Unary ops (CLZ, CTZ, CPOP, SEXT, ZEXT, ORC.B, REV8) ignore B.
- Counting ops return values 0..32 zero-extended. CLZ(0)=32, CTZ(0)=32, CPOP(0xFFFFFFFF)=32.
- All arithmetic wraps modulo 2^32; no overflow flag is produced.
- Shift and rotate amounts use only B[4:0]; upper bits are ignored.
- res_o is registered. Latency is 1 cycle: inputs sampled at edge N appear on res_o after edge N.
- A new operation is accepted every cycle.
- Reset: res_o = 0 immediately when rst_n falls, independent of clk, and held while rst_n = 0. The first capture happens on the first rising edge after rst_n deasserts.
- Mux selects and alu_op_i are sampled only with the data; no internal state besides res_o.

Optional Feature:
- Macro RV_EXEC_MUL_EN.
- Defined: 11011 MUL (low 32 bits), 11100 MULH (signed×signed, high 32), 11101 MULHSU (signed A × unsigned B, high 32), 11110 MULHU (unsigned×unsigned, high 32). The product is computed combinationally; latency is still 1 cycle.
- Not defined: codes 11011-11110 yield 0, and no multiplier logic is synthesized.

Test Plan:
- Reset: hold rst_n=0 with arbitrary inputs → res_o=0. Assert rst_n mid-operation, off a clock edge → res_o=0 immediately.
- Zbb counts, all data inputs 0x0000000A, mux1=00, mux2=00, mux3=0: alu_op 00001 → res_o=28 one cycle later; 00010 → 1; 00011 → 2. rs1=0: CLZ and CTZ → 32.
- Forwarding: rs1=1, ex_mem=5, mem_wb=9, rs2=2, ADD. mux1=01, mux2=00 → 7. mux1=10, mux2=01 → 14.
- Immediate path: rs1=10, imm=0xFFFFFFFD, mux3=1, ADD → 7. SUB with rs2=11, mux3=0 → 0xFFFFFFFF.
- Signed vs unsigned: A=0xFFFFFFFF, B=1. SLT → 1, SLTU → 0, MIN → 0xFFFFFFFF, MINU → 1, SRA by 4 → 0xFFFFFFFF.
- Byte ops: A=0x12003400. REV8 → 0x00340012, ORC.B → 0xFF00FF00, ROL by 8 → 0x00340012. With RV_EXEC_MUL_EN, MULHU of 0xFFFFFFFF×2 → 1.
